// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command/response endpoint.
package uart_cmd_pkg;

  localparam int unsigned CMD_BYTES = 3;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with registered occupancy count; a push while full only lands
// when a pop frees a slot in the same cycle.
module resp_fifo
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cmd_aggregator.sv
// Assembles 3-byte commands from the UART receiver and drains buffered response
// bytes to the UART transmitter one at a time.
module cmd_aggregator
  import uart_cmd_pkg::*;
#(
  parameter int unsigned RESP_DEPTH   = 8,
  parameter int unsigned IDLE_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_full,
  output logic        cmd_overrun,
  output logic        resp_drop
);

  localparam int unsigned IdleW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);
  localparam logic [1:0] LastIdx = 2'(CMD_BYTES - 1);
  localparam int unsigned CntW = $clog2(RESP_DEPTH) + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(RESP_DEPTH);

  // RX assembly state
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [23:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             overrun_q, overrun_d;
  logic             frame_done;

  // Response path state
  tx_state_t        state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             trmt_q, trmt_d;
  logic             drop_q, drop_d;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;

  assign frame_done = rx_rdy && (idx_q == LastIdx);

  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    idle_d    = idle_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    overrun_d = 1'b0;
    if (rx_rdy) begin
      idle_d = '0;
      if (frame_done) begin
        idx_d = 2'd0;
        if (!cmd_rdy_q || clr_cmd_rdy) begin
          cmd_d     = {shadow_q, rx_data};
          cmd_rdy_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        shadow_d = (idx_q == 2'd0) ? {rx_data, shadow_q[7:0]} : {shadow_q[15:8], rx_data};
        idx_d    = idx_q + 2'd1;
      end
    end else if (idx_q != 2'd0) begin
      // A stalled partial frame is abandoned; cmd/cmd_rdy are left alone.
      if (idle_q == IdleLast) begin
        idx_d  = 2'd0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
    if (!frame_done && clr_cmd_rdy) cmd_rdy_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    trmt_d    = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = fifo_dout;
          trmt_d    = 1'b1;
          state_d   = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) state_d = TX_IDLE;
      end
    endcase
    drop_d = send_resp && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      idle_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
      trmt_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      idle_q    <= idle_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      drop_q    <= drop_d;
    end
  end

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (8)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send_resp),
    .pop   (pop),
    .din   (resp_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign cmd_overrun = overrun_q;
  assign tx_data     = tx_data_q;
  assign trmt        = trmt_q;
  assign resp_drop   = drop_q;
  assign resp_full   = (fifo_count == FullCount);

endmodule
